imem_boot_loader: RTL

Boot-time controller for the byte-streamed instruction memory. It accepts a program one 32-bit word at a time from a host port and buffers the whole program. It then drives the memory's 8-bit load port with a framed stream (0xFE start marker, gapless MSB-first bytes, 0xFF end marker). The CPU core is held in reset until the load completes.

---
 rtl/imem_boot_loader_if.sv | 15 +
 rtl/imem_boot_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_boot_loader_if : host word-write handshake into the boot loader
// Revision: 1.0
// ----------------------------------------------------------------------------
interface imem_boot_loader_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_boot_loader : buffers a host program, then streams it framed to imem
// Revision: 1.0
// ----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int MAX_WORDS = 64,
  parameter int CW        = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  imem_boot_loader_if.slave wr,
  input  logic              reload,
  output logic              imem_rst,
  output logic [7:0]        imem_byte,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     word_count
);
  localparam int AW = $clog2(MAX_WORDS);
  localparam int IW = CW + 2;
  localparam logic [7:0] c_SOF_BYTE  = 8'hFE;
  localparam logic [7:0] c_EOF_BYTE  = 8'hFF;
  localparam logic [7:0] c_IDLE_BYTE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_GAP  = 3'd2,
    S_SOF  = 3'd3,
    S_DATA = 3'd4,
    S_EOF  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_buf [MAX_WORDS];
  logic            r_bad;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_next_idx;
  logic [IW-1:0]   w_last_idx;
  logic            w_hs;
  logic            w_word_bad;
  logic            w_coll_end;
  logic            w_reload;
  logic [31:0]     w_rd_word;
  logic [7:0]      w_next_byte;

  // wr_ready is registered high exactly while the FSM sits in IDLE
  assign w_hs       = wr.wr_valid & wr.wr_ready;
  assign w_word_bad = (wr.wr_data[31:24] == 8'hFF) | (wr.wr_data[23:16] == 8'hFF) |
                      (wr.wr_data[15:8]  == 8'hFF) | (wr.wr_data[7:0]   == 8'hFF);
  assign w_coll_end = w_hs & (wr.wr_last | (word_count == CW'(MAX_WORDS - 1)));
  assign w_reload   = reload & ((r_state == S_DONE) | (r_state == S_ERR));
  assign w_last_idx = {word_count, 2'b00} - IW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = '0;
    case (r_state)
      S_IDLE: if (w_coll_end) w_next_state = (r_bad | w_word_bad) ? S_ERR : S_CLR;
      S_CLR:  w_next_state = S_GAP;
      S_GAP:  w_next_state = S_SOF;
      S_SOF:  w_next_state = S_DATA;
      S_DATA: begin
        if (r_idx == w_last_idx) w_next_state = S_EOF;
        else                     w_next_idx   = r_idx + IW'(1);
      end
      S_EOF:  w_next_state = S_DONE;
      S_DONE: if (reload) w_next_state = S_IDLE;
      S_ERR:  if (reload) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    // Byte for the next cycle is selected now so word k+1 follows word k gaplessly
    w_rd_word = r_buf[w_next_idx[AW+1:2]];
    case (w_next_state)
      S_SOF:  w_next_byte = c_SOF_BYTE;
      S_EOF:  w_next_byte = c_EOF_BYTE;
      S_DATA: begin
        case (w_next_idx[1:0])
          2'd0:    w_next_byte = w_rd_word[31:24];
          2'd1:    w_next_byte = w_rd_word[23:16];
          2'd2:    w_next_byte = w_rd_word[15:8];
          default: w_next_byte = w_rd_word[7:0];
        endcase
      end
      default: w_next_byte = c_IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr.wr_ready <= 1'b0;
      imem_rst    <= 1'b0;
      imem_byte   <= 8'h00;
      cpu_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      word_count  <= '0;
      r_bad       <= 1'b0;
      r_idx       <= '0;
    end else begin
      wr.wr_ready <= (w_next_state == S_IDLE);
      imem_rst    <= (w_next_state == S_CLR);
      imem_byte   <= w_next_byte;
      cpu_rst_n   <= (w_next_state == S_DONE);
      busy        <= (w_next_state inside {S_CLR, S_GAP, S_SOF, S_DATA, S_EOF});
      done        <= (w_next_state == S_DONE);
      err         <= (w_next_state == S_ERR);
      r_idx       <= w_next_idx;
      if (w_reload) begin
        word_count <= '0;
        r_bad      <= 1'b0;
      end else if (w_hs) begin
        word_count <= word_count + CW'(1);
        r_bad      <= r_bad | w_word_bad;
      end
    end
  end

  // Program storage needs no reset; a fresh load always overwrites what it streams
  always_ff @(posedge clk) begin
    if (w_hs) r_buf[word_count[AW-1:0]] <= wr.wr_data;
  end

endmodule
`default_nettype wire
